// File: rtl/id_decode_stage_if.sv
// Signal bundle around the ID stage: IF/ID inputs, MEM/WB write-back, hazard taps and the ID/EX outputs.
// The decode stage connects through the slave modport; the surrounding pipeline uses master.
interface id_decode_stage_if #(
   parameter int B = 32,
   parameter int W = 5
);
   // IF/ID latch
   logic [31:0]  instruction_in;
   logic [B-1:0] pc_next_in;
   // MEM/WB write-back port
   logic         wb_RegWrite_in;
   logic [W-1:0] wb_addr_in;
   logic [B-1:0] wb_data_in;
   // ID/EX taps used by hazard detection
   logic         ex_MemRead_in;
   logic [W-1:0] ex_rt_in;
   // data towards ID/EX
   logic [B-1:0] pc_next_out;
   logic [B-1:0] r_data1_out;
   logic [B-1:0] r_data2_out;
   logic [B-1:0] sign_ext_out;
   logic [W-1:0] inst_20_16_out;
   logic [W-1:0] inst_15_11_out;
   logic [B-1:0] pc_jump_out;
   logic [5:0]   opcode_out;
   // control towards ID/EX
   logic         wb_RegWrite_out;
   logic         wb_MemtoReg_out;
   logic         m_Jump_out;
   logic         m_Branch_out;
   logic         m_BranchNot_out;
   logic         m_MemRead_out;
   logic         m_MemWrite_out;
   logic         ex_RegDst_out;
   logic         ex_ALUSrc_out;
   logic [5:0]   ex_ALUOp_out;
   // hazard unit
   logic         stall_out;

   modport master (
      output instruction_in, pc_next_in,
      output wb_RegWrite_in, wb_addr_in, wb_data_in,
      output ex_MemRead_in, ex_rt_in,
      input  pc_next_out, r_data1_out, r_data2_out, sign_ext_out,
      input  inst_20_16_out, inst_15_11_out, pc_jump_out, opcode_out,
      input  wb_RegWrite_out, wb_MemtoReg_out, m_Jump_out, m_Branch_out,
      input  m_BranchNot_out, m_MemRead_out, m_MemWrite_out,
      input  ex_RegDst_out, ex_ALUSrc_out, ex_ALUOp_out,
      input  stall_out
   );

   modport slave (
      input  instruction_in, pc_next_in,
      input  wb_RegWrite_in, wb_addr_in, wb_data_in,
      input  ex_MemRead_in, ex_rt_in,
      output pc_next_out, r_data1_out, r_data2_out, sign_ext_out,
      output inst_20_16_out, inst_15_11_out, pc_jump_out, opcode_out,
      output wb_RegWrite_out, wb_MemtoReg_out, m_Jump_out, m_Branch_out,
      output m_BranchNot_out, m_MemRead_out, m_MemWrite_out,
      output ex_RegDst_out, ex_ALUSrc_out, ex_ALUOp_out,
      output stall_out
   );
endinterface

// File: rtl/id_decode_stage.sv
// MIPS-style instruction decode stage: register file, main control decode and load-use hazard detection.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write-back value onto the read ports.
module id_decode_stage #(
   parameter int B = 32,
   parameter int W = 5
) (
   input  logic            clk,
   input  logic            reset,
   id_decode_stage_if.slave bus
);

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_BEQ   = 6'h04,
      OP_BNE   = 6'h05,
      OP_ADDI  = 6'h08,
      OP_SLTI  = 6'h0A,
      OP_ANDI  = 6'h0C,
      OP_ORI   = 6'h0D,
      OP_LUI   = 6'h0F,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B
   } opcode_e;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic jump;
      logic branch;
      logic branch_not;
      logic mem_read;
      logic mem_write;
      logic reg_dst;
      logic alu_src;
   } ctrl_t;

   logic [B-1:0] regs [32];
   logic [5:0]   opcode;
   logic [W-1:0] rs_addr;
   logic [W-1:0] rt_addr;
   logic [B-1:0] rs_data;
   logic [B-1:0] rt_data;
   logic         uses_rt;
   logic         stall;
   logic         decoded;
   ctrl_t        ctrl;
   logic [5:0]   alu_op;

   assign opcode  = bus.instruction_in[31:26];
   assign rs_addr = bus.instruction_in[25:21];
   assign rt_addr = bus.instruction_in[20:16];

   // NOTE: the whole array is cleared on reset, so it maps to flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.wb_RegWrite_in && (bus.wb_addr_in != '0)) begin
         regs[bus.wb_addr_in] <= bus.wb_data_in;
      end
   end

   always_comb begin
      rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
      rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef REGFILE_BYPASS_EN
      // Forward only what the register file would actually accept this edge.
      if (reset && bus.wb_RegWrite_in && (bus.wb_addr_in != '0)) begin
         if (rs_addr == bus.wb_addr_in) rs_data = bus.wb_data_in;
         if (rt_addr == bus.wb_addr_in) rt_data = bus.wb_data_in;
      end
`endif
   end

   // Only these opcodes read rt as a source; for the rest rt is a destination.
   assign uses_rt = opcode inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};

   assign stall = reset && bus.ex_MemRead_in && (bus.ex_rt_in != '0) &&
                  ((bus.ex_rt_in == rs_addr) || ((bus.ex_rt_in == rt_addr) && uses_rt));

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      ctrl    = '0;
      alu_op  = '0;
      decoded = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_LW: begin
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
         end
         OP_SW: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
         end
         OP_BEQ: ctrl.branch     = 1'b1;
         OP_BNE: ctrl.branch_not = 1'b1;
         OP_J:   ctrl.jump       = 1'b1;
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
         end
         default: decoded = 1'b0;
      endcase
      if (decoded) alu_op = opcode;
      // Reset and load-use stalls both inject a bubble into ID/EX.
      if (!reset || stall) begin
         ctrl   = '0;
         alu_op = '0;
      end
   end

   assign bus.pc_next_out    = bus.pc_next_in;
   assign bus.r_data1_out    = rs_data;
   assign bus.r_data2_out    = rt_data;
   assign bus.sign_ext_out   = {{(B-16){bus.instruction_in[15]}}, bus.instruction_in[15:0]};
   assign bus.inst_20_16_out = bus.instruction_in[20:16];
   assign bus.inst_15_11_out = bus.instruction_in[15:11];
   assign bus.pc_jump_out    = {bus.pc_next_in[B-1:B-4], bus.instruction_in[25:0], 2'b00};
   assign bus.opcode_out     = opcode;

   assign bus.wb_RegWrite_out = ctrl.reg_write;
   assign bus.wb_MemtoReg_out = ctrl.mem_to_reg;
   assign bus.m_Jump_out      = ctrl.jump;
   assign bus.m_Branch_out    = ctrl.branch;
   assign bus.m_BranchNot_out = ctrl.branch_not;
   assign bus.m_MemRead_out   = ctrl.mem_read;
   assign bus.m_MemWrite_out  = ctrl.mem_write;
   assign bus.ex_RegDst_out   = ctrl.reg_dst;
   assign bus.ex_ALUSrc_out   = ctrl.alu_src;
   assign bus.ex_ALUOp_out    = alu_op;
   assign bus.stall_out       = stall;

endmodule
